spike_rate_monitor: RTL
=======================

# spike_rate_monitor

Downstream consumer of the `spiking_neuron` spike output. It counts spike rising edges over a fixed measurement window, latches the per-window spike rate, and measures the inter-spike interval (ISI) between consecutive spikes. It drives the 7-segment display with the latched rate and a retriggerable LED pulse so activity is visible on the board. It sits between the neuron's `spike` output and the top-level `uo_out` / `uio_out` pins.

## Interface
- `WINDOW_CYCLES`, default 24'd10_000_000: measurement window length in clock cycles; legal range is 2 to 2^24-1.
- `STRETCH_CYCLES`, default 24'd1_000_000: LED on-time after each spike edge.
- `clk`  input  1  system clock.
- `reset`  input  1  asynchronous, active-high reset.
- `en`  input  1  measurement enable.
- `spike`  input  1  neuron spike output; synchronous to `clk`, no synchronizer.
- `rate`  output  8  spike edges counted in the last completed window, saturating at 255.
- `rate_valid`  output  1  one-cycle pulse when `rate` updates.
- `isi`  output  16  cycles between the last two spike edges, saturating at 16'hFFFF.
- `isi_valid`  output  1  one-cycle pulse when `isi` updates.
- `seg`  output  7  active-high segments {g,f,e,d,c,b,a} showing min(`rate`,15) as a hex digit.
- `spike_led`  output  1  stretched spike indicator.

## Operation
- Edge detect:
  - Register `spike_d` each cycle.
  - An edge is the cycle where `spike`=1 and `spike_d`=0.
  - A multi-cycle high pulse counts once.
  - `spike_d` resets to 0.
- FSM states are IDLE, RUN and LATCH.
  - IDLE: entered on reset. Window counter, spike counter and ISI counter are held at 0, and the ISI-armed flag is cleared. `en`=1 moves to RUN.
  - RUN: the window counter increments by 1 each cycle from 0. When it reaches WINDOW_CYCLES-1, go to LATCH. An edge in that terminal cycle belongs to the closing window. `en`=0 moves to IDLE and discards the partial window.
  - LATCH: lasts one cycle.
    - Load `rate` with the spike count and pulse `rate_valid`.
    - Restart the window counter at 0 and the spike count at 0, or at 1 if an edge occurs in this cycle.
    - Return to RUN, or to IDLE if `en`=0.
- Spike count: 8-bit, saturates at 255 and never wraps.
- ISI:
  - The first edge after entering RUN sets the armed flag and clears the ISI counter; it produces no output.
  - Each later edge loads `isi` with the counter value plus 1, pulses `isi_valid`, and clears the counter.
  - The counter saturates at 16'hFFFF.
  - ISI measurement continues across window boundaries.
- LED:
  - Each edge in any state loads the stretch counter with STRETCH_CYCLES-1.
  - `spike_led` is 1 while the stretch counter is nonzero or in the load cycle.
  - The stretch is retriggerable.
- Outputs `rate` and `isi` keep their last values in IDLE.

## Timing
- Reset values: `rate`=0, `rate_valid`=0, `isi`=0, `isi_valid`=0, `spike_led`=0, `seg`=7'b0111111 (digit 0).
- All outputs are registered except `seg`, which is combinational from `rate`.
- `rate_valid` asserts the cycle after the terminal RUN cycle. The first window after `en` rises ends after WINDOW_CYCLES cycles in RUN. Later windows are WINDOW_CYCLES cycles long, LATCH cycle included.
- `isi_valid` and the new `isi` appear the cycle after the second edge. With edges at cycles t0 and t1, `isi` = t1-t0.
- `spike_led` rises the cycle after an edge and stays high for exactly STRETCH_CYCLES cycles after the last edge.
- Reset asserted mid-window clears everything immediately, with no `rate_valid`. Deasserting reset lands in IDLE.
- `en` dropping and an edge in the same cycle: the edge is ignored for count and ISI, but still retriggers the LED.

## Structure
- Shared package `tinysnn_pkg`:
  - FSM state enum `mon_state_t` (IDLE, RUN, LATCH).
  - Width constants `RATE_W`=8 and `ISI_W`=16.
  - 7-segment digit constants.
- One sub-module `seg7_decoder`: 4-bit to 7-segment combinational decoder, reusable by other display paths.

## Test plan
- Reset mid-run: WINDOW_CYCLES=16, five 1-cycle spikes in window, assert `reset` at cycle 10 -> all outputs return to reset values with no `rate_valid`; after release, `rate` stays 0 until a full window completes.
- Basic rate: WINDOW_CYCLES=16, `en`=1, 1-cycle spikes every 4 cycles starting at cycle 1 -> `rate`=4, `rate_valid` one cycle after terminal count, `seg`=7'b1100110 (digit 4).
- Saturation: WINDOW_CYCLES=600, `spike` toggling every cycle (300 edges) -> `rate`=255 and `seg` shows F (7'b1110001).
- ISI: spikes at cycles 5, 12 and 40 after `en` -> first edge gives no `isi_valid`; then `isi`=7, then `isi`=28, each with a single `isi_valid` pulse.
- Long pulse and boundary:
  - `spike` held high 10 cycles -> counts as 1.
  - An edge on the terminal window cycle counts in the closing window.
  - An edge in the LATCH cycle gives the next window's count a start of 1.
- LED stretch: STRETCH_CYCLES=8, edges at cycles 0 and 5 -> `spike_led` high cycles 1–13 continuous, low at 14.

Source files
------------

// File: rtl/tinysnn_pkg.sv
// rtl/tinysnn_pkg.sv - shared types and constants for the tinysnn spike monitor path
package tinysnn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LATCH = 2'd2
  } mon_state_t;

  localparam int RATE_W = 8;
  localparam int ISI_W  = 16;

  // Active-high segments ordered {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111101;
  localparam logic [6:0] SEG_7 = 7'b0000111;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1101111;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b1111100;
  localparam logic [6:0] SEG_C = 7'b0111001;
  localparam logic [6:0] SEG_D = 7'b1011110;
  localparam logic [6:0] SEG_E = 7'b1111001;
  localparam logic [6:0] SEG_F = 7'b1110001;

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - 4-bit hex digit to active-high 7-segment pattern
module seg7_decoder
  import tinysnn_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_0;
    case (digit)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/spike_rate_monitor.sv
// rtl/spike_rate_monitor.sv - windowed spike rate, inter-spike interval and LED stretch for the neuron output
module spike_rate_monitor
  import tinysnn_pkg::*;
#(
  parameter logic [23:0] WINDOW_CYCLES  = 24'd10_000_000,
  parameter logic [23:0] STRETCH_CYCLES = 24'd1_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              spike,
  output logic [RATE_W-1:0] rate,
  output logic              rate_valid,
  output logic [ISI_W-1:0]  isi,
  output logic              isi_valid,
  output logic [6:0]        seg,
  output logic              spike_led
);

  mon_state_t         state, state_next;
  logic               spike_d;
  logic               spike_edge;
  logic [23:0]        win_cnt;
  logic [RATE_W-1:0]  spike_cnt;
  logic [RATE_W-1:0]  spike_cnt_inc;
  logic [ISI_W-1:0]   isi_cnt;
  logic               isi_armed;
  logic [23:0]        stretch_cnt;
  logic               meas_active;
  logic               in_idle;
  logic               in_latch;
  logic               win_terminal;
  logic               count_edge;
  logic [3:0]         seg_digit;

  assign spike_edge    = spike && !spike_d;
  assign count_edge    = spike_edge && meas_active;
  assign spike_cnt_inc = (count_edge && spike_cnt != '1) ? spike_cnt + 1'b1 : spike_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en) state_next = RUN;
      RUN:     if (!en) state_next = IDLE;
               else if (win_cnt == WINDOW_CYCLES - 24'd1) state_next = LATCH;
      LATCH:   state_next = en ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    meas_active  = 1'b0;
    in_idle      = 1'b0;
    in_latch     = 1'b0;
    win_terminal = 1'b0;
    case (state)
      IDLE:    in_idle = 1'b1;
      RUN: begin
        meas_active  = en;
        win_terminal = en && (win_cnt == WINDOW_CYCLES - 24'd1);
      end
      LATCH: begin
        meas_active = en;
        in_latch    = 1'b1;
      end
      default: in_idle = 1'b1;
    endcase
  end

  // The LATCH cycle is slot 0 of the following window, so RUN resumes at 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spike_d    <= 1'b0;
      win_cnt    <= '0;
      spike_cnt  <= '0;
      rate       <= '0;
      rate_valid <= 1'b0;
    end else begin
      spike_d    <= spike;
      rate_valid <= 1'b0;
      if (!meas_active) begin
        win_cnt   <= '0;
        spike_cnt <= '0;
      end else if (in_latch) begin
        win_cnt   <= 24'd1;
        spike_cnt <= count_edge ? RATE_W'(1) : '0;
      end else begin
        win_cnt   <= win_cnt + 24'd1;
        spike_cnt <= spike_cnt_inc;
        if (win_terminal) begin
          rate       <= spike_cnt_inc;
          rate_valid <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      isi_cnt   <= '0;
      isi_armed <= 1'b0;
      isi       <= '0;
      isi_valid <= 1'b0;
    end else begin
      isi_valid <= 1'b0;
      if (in_idle) begin
        isi_cnt   <= '0;
        isi_armed <= 1'b0;
      end else if (count_edge) begin
        if (isi_armed) begin
          isi       <= (isi_cnt == '1) ? '1 : isi_cnt + 1'b1;
          isi_valid <= 1'b1;
        end
        isi_cnt   <= '0;
        isi_armed <= 1'b1;
      end else if (isi_cnt != '1) begin
        isi_cnt <= isi_cnt + 1'b1;
      end
    end
  end

  // LED follows every edge, even when measurement is off.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stretch_cnt <= '0;
      spike_led   <= 1'b0;
    end else begin
      spike_led <= spike_edge || (stretch_cnt != '0);
      if (spike_edge)             stretch_cnt <= STRETCH_CYCLES - 24'd1;
      else if (stretch_cnt != '0) stretch_cnt <= stretch_cnt - 24'd1;
    end
  end

  assign seg_digit = (rate > RATE_W'(15)) ? 4'hF : rate[3:0];

  seg7_decoder u_seg7 (
    .digit (seg_digit),
    .seg   (seg)
  );

endmodule
